// File: rtl/uno_feeder_pkg.sv
// Shared types and constants for the uno ifm feeder: FSM state encoding,
// default element width and the XSEL select width.
package uno_feeder_pkg;

  localparam int unsigned MAC_BW = 8;
  localparam int unsigned XSEL_W = 2;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_STREAM,
    FEED_DRAIN
  } feed_state_e;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line, shifting every cycle, with synchronous active-high clear.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/uno_ifm_feeder.sv
// ifm operand feeder for a column of uno PEs: counts tile beats, skews row r by r cycles,
// drains and pulses done. Optional XSEL forwarding under `UNO_FEEDER_XSEL_EN.
module uno_ifm_feeder
  import uno_feeder_pkg::*;
#(
  parameter int unsigned ROWS = 4,   // 1..32
  parameter int unsigned DW   = MAC_BW,
  parameter int unsigned LW   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LW-1:0]          cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DW-1:0]     in_data,
`ifdef UNO_FEEDER_XSEL_EN
  input  logic [XSEL_W-1:0]      in_xsel,
  output logic [ROWS*XSEL_W-1:0] o_xsel,
`endif
  output logic [ROWS*DW-1:0]     o_data,
  output logic [ROWS-1:0]        o_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(ROWS - 1);
`ifdef UNO_FEEDER_XSEL_EN
  localparam int unsigned SW = 1 + XSEL_W + DW;
`else
  localparam int unsigned SW = 1 + DW;
`endif

  feed_state_e    r_state, w_state_nxt;
  logic [LW-1:0]  r_len, r_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_zero_done;
  logic           w_accept, w_drain_end;

  assign in_ready = (r_state == FEED_STREAM) && (r_cnt < r_len);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_end = 1'b0;
    case (r_state)
      FEED_IDLE:
        if (start && (cfg_len != '0)) w_state_nxt = FEED_STREAM;
      FEED_STREAM:
        if (w_accept && (r_cnt == r_len - 1'b1)) w_state_nxt = FEED_DRAIN;
      FEED_DRAIN:
        if (r_drain_cnt == LAST_DRAIN) begin
          w_drain_end = 1'b1;
          w_state_nxt = FEED_IDLE;
        end
      default: w_state_nxt = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FEED_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // a zero-length tile never leaves IDLE, so its done comes from this flag
      r_zero_done <= (r_state == FEED_IDLE) && start && (cfg_len == '0);
      if ((r_state == FEED_IDLE) && start) begin
        r_len <= cfg_len;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FEED_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                       r_drain_cnt <= '0;
    end
  end

  assign busy = (r_state != FEED_IDLE);
  assign done = w_drain_end | r_zero_done;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [SW-1:0] w_d, w_q;

`ifdef UNO_FEEDER_XSEL_EN
    assign w_d = w_accept ? {1'b1, in_xsel, in_data[r*DW +: DW]} : '0;
    assign o_xsel[r*XSEL_W +: XSEL_W] = w_q[DW +: XSEL_W];
`else
    assign w_d = w_accept ? {1'b1, in_data[r*DW +: DW]} : '0;
`endif

    skew_line #(
      .DEPTH (r + 1),
      .W     (SW)
    ) u_line (
      .i_clk (clk),
      .i_clr (rst),
      .i_d   (w_d),
      .o_q   (w_q)
    );

    assign o_valid[r]           = w_q[SW-1];
    assign o_data[r*DW +: DW]   = w_q[DW-1:0];
  end

endmodule

// File: tb/tb_uno_ifm_feeder.sv
// Scoreboard bench for uno_ifm_feeder (ROWS=4): per-row expected queues tagged with arrival cycle.
module tb_uno_ifm_feeder;

  localparam int unsigned ROWS = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned LW   = 16;

  logic                 clk = 1'b0;
  logic                 rst, start, in_valid;
  logic [LW-1:0]        cfg_len;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic [ROWS*DW-1:0]   o_data;
  logic [ROWS-1:0]      o_valid;
  logic                 busy, done;
`ifdef UNO_FEEDER_XSEL_EN
  logic [1:0]           in_xsel;
  logic [ROWS*2-1:0]    o_xsel;
`endif

  uno_ifm_feeder #(.ROWS(ROWS), .DW(DW), .LW(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef UNO_FEEDER_XSEL_EN
    .in_xsel  (in_xsel),
    .o_xsel   (o_xsel),
`endif
    .o_data   (o_data),
    .o_valid  (o_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    xsel;
    int unsigned   cyc;
  } exp_t;

  exp_t        q_row [ROWS][$];
  int unsigned q_done[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int tile, input int beat, input int r);
    elem = DW'(tile * 64 + beat * 4 + r + 1);
  endfunction

  function automatic int pending();
    int n = q_done.size();
    for (int r = 0; r < ROWS; r++) n += q_row[r].size();
    return n;
  endfunction

  task automatic monitor();
    for (int r = 0; r < ROWS; r++) begin
      if (o_valid[r]) begin
        if (q_row[r].size() == 0) begin
          check_eq($sformatf("row%0d_spurious", r), 32'(o_valid[r]), 0);
        end else begin
          exp_t e;
          e = q_row[r].pop_front();
          check_eq($sformatf("row%0d_data", r), 32'(o_data[r*DW +: DW]), 32'(e.data));
          check_eq($sformatf("row%0d_cycle", r), cyc, e.cyc);
`ifdef UNO_FEEDER_XSEL_EN
          check_eq($sformatf("row%0d_xsel", r), 32'(o_xsel[r*2 +: 2]), 32'(e.xsel));
`endif
        end
      end else begin
        check_eq($sformatf("row%0d_bubble", r), 32'(o_data[r*DW +: DW]), 0);
        if (q_row[r].size() > 0 && q_row[r][0].cyc <= cyc) begin
          void'(q_row[r].pop_front());
          check_eq($sformatf("row%0d_missing", r), 32'(o_valid[r]), 1);
        end
      end
    end
    if (done) begin
      if (q_done.size() == 0) check_eq("done_spurious", 32'(done), 0);
      else                    check_eq("done_cycle", cyc, q_done.pop_front());
    end else if (q_done.size() > 0 && q_done[0] <= cyc) begin
      void'(q_done.pop_front());
      check_eq("done_missing", 32'(done), 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic run_tile(input int tile, input int len, input int stall_cycles,
                          input bit restart_mid, input bit rst_in_drain);
    int sent = 0, stall = 0, guard = 0;
    start = 1'b1; cfg_len = LW'(len);
    tick();
    start = 1'b0;
    check_eq("busy_start", 32'(busy), 1);
    while (sent < len && guard < 1000) begin
      in_valid = !(sent == 1 && stall < stall_cycles);
      for (int r = 0; r < ROWS; r++) in_data[r*DW +: DW] = elem(tile, sent, r);
`ifdef UNO_FEEDER_XSEL_EN
      in_xsel = (sent == 1) ? 2'b10 : 2'b01;
`endif
      if (restart_mid && sent == 1) begin
        start = 1'b1; cfg_len = LW'(len + 5);
      end
      if (in_valid && in_ready) begin
        for (int r = 0; r < ROWS; r++) begin
          exp_t e;
          e.data = elem(tile, sent, r);
          e.xsel = (sent == 1) ? 2'b10 : 2'b01;
          e.cyc  = cyc + 1 + r;
          q_row[r].push_back(e);
        end
        if (sent == len - 1) q_done.push_back(cyc + ROWS);
        sent++;
      end else if (!in_valid) begin
        stall++;
      end
      tick();
      start = 1'b0;
      guard++;
    end
    check_eq("beats_accepted", sent, len);
    in_valid = rst_in_drain ? 1'b0 : 1'b1;
    if (rst_in_drain) begin
      tick();
      for (int r = 0; r < ROWS; r++) q_row[r].delete();
      q_done.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rst_o_valid", 32'(o_valid), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_in_ready", 32'(in_ready), 0);
      repeat (ROWS + 2) tick();
    end else begin
      guard = 0;
      while (q_done.size() > 0 && guard < 40) begin
        check_eq("drain_in_ready", 32'(in_ready), 0);
        tick();
        guard++;
      end
      check_eq("drain_timeout", 32'(guard < 40), 1);
      check_eq("busy_in_done", 32'(busy), 1);
      in_valid = 1'b0;
      start = 1'b1; cfg_len = LW'(len);
      tick();
      start = 1'b0;
      check_eq("start_in_done_ignored", 32'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; cfg_len = '0; in_data = '0;
`ifdef UNO_FEEDER_XSEL_EN
    in_xsel = 2'b00;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_in_ready", 32'(in_ready), 0);
    check_eq("reset_o_valid", 32'(o_valid), 0);
    check_eq("reset_o_data", o_data, 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_done", 32'(done), 0);
    tick();

    run_tile(0, 3, 0, 1'b0, 1'b0);
    run_tile(0, 3, 2, 1'b0, 1'b0);

    start = 1'b1; cfg_len = '0;
    q_done.push_back(cyc + 1);
    tick();
    start = 1'b0;
    check_eq("zero_len_busy", 32'(busy), 0);
    tick();
    check_eq("zero_len_busy_after", 32'(busy), 0);
    check_eq("zero_len_o_valid", 32'(o_valid), 0);
    repeat (2) tick();

    run_tile(1, 3, 0, 1'b1, 1'b0);
    run_tile(2, 5, 0, 1'b0, 1'b1);
    run_tile(3, 3, 0, 1'b0, 1'b0);
    run_tile(1, 20, 1, 1'b0, 1'b0);

    repeat (ROWS + 2) tick();
    check_eq("scoreboard_empty", pending(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uno_ifm_feeder.md
# uno_ifm_feeder

Upstream operand feeder for a column of `uno` PEs in the systolic array. Accepts one ROWS-wide ifm vector per beat over a valid/ready handshake and counts beats against a programmed tile length. Skews each element so that row r sees it r cycles after row 0, then drains the skew pipeline and pulses done. Outputs drive the PE `ifm` inputs directly, and the `XSEL` select when that option is enabled.

## Interface
- `ROWS`, 4: number of PE rows fed; legal range 1..32.
- `DW`, `MAC_BW`: element width.
- `LW`, 16: width of the tile-length field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high; clears all state.
- `start` in 1: latches `cfg_len`; honoured only in IDLE.
- `cfg_len` in LW: number of beats in the tile.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: feeder can accept a beat.
- `in_data` in ROWS*DW: element r sits at bits [r*DW +: DW].
- `o_data` out ROWS*DW: skewed per-row element, registered.
- `o_valid` out ROWS: per-row valid, skewed with the data.
- `busy` out 1: a tile is in progress.
- `done` out 1: one-cycle pulse at the end of the tile.

## Operation
- FSM states are IDLE, STREAM and DRAIN.
- IDLE → STREAM on `start` with `cfg_len`≠0; `len` and `cnt` are latched.
- IDLE with `start` and `cfg_len`=0:
  - `done` pulses on the next cycle.
  - The FSM stays in IDLE and no output is valid.
- STREAM:
  - `in_ready` = 1 while `cnt` < `len`.
  - A beat is accepted on `in_valid & in_ready`, and `cnt` increments.
  - On the edge that accepts beat `len`, the FSM moves to DRAIN, `in_ready` drops and `drain_cnt` = 0.
- DRAIN:
  - `in_ready` = 0.
  - `drain_cnt` counts to ROWS-1, then the FSM moves to IDLE.
  - `done` is asserted in the final DRAIN cycle.
- `start` in STREAM or DRAIN is ignored, and `cfg_len` is not re-latched.
- Skew chain:
  - Row r is a delay line of r+1 registers carrying data and valid.
  - Every stage shifts every cycle, with no stall.
  - A cycle with no accepted beat injects valid=0 and data=0 into every row (a bubble).
- Stalled input (`in_valid`=0 in STREAM) produces bubbles; order is preserved and beats are never duplicated or dropped.
- `busy` is 1 from the cycle after `start` is accepted through the `done` cycle inclusive.
- Reset mid-tile:
  - On the next edge, all pipeline stages, `o_valid` and `o_data` go to 0 and the FSM goes to IDLE.
  - No `done` pulse is issued.
- Reset values: `in_ready`=0, `o_data`=0, `o_valid`=0, `busy`=0, `done`=0.
- `cfg_len` = 2^LW-1 is legal; `cnt` is LW bits wide and never wraps.

## Timing
- A beat accepted at edge t appears on row r during cycle t+1+r.
- Last beat accepted at edge T:
  - Row ROWS-1 shows it in cycle T+ROWS.
  - `done` is high in cycle T+ROWS.
  - `in_ready` is low from cycle T+1.
- Throughput is 1 beat/cycle; the minimum tile time is `len`+ROWS cycles after `start`.
- Back-to-back tiles: `start` in the `done` cycle is ignored because the FSM is still in DRAIN; `start` on the following cycle is accepted.

## Configuration
- `UNO_FEEDER_XSEL_EN`, when defined:
  - Adds input `in_xsel` (2 bits, per beat) and output `o_xsel` (ROWS*2).
  - `in_xsel` is skewed identically to the data, so PE row r receives the select aligned with its operand.
  - Bubbles carry `o_xsel`=2'b00, and `o_xsel` resets to 0.
- Not defined: the ports are absent and the PEs tie `XSEL` locally.

## Structure
- Package `uno_feeder_pkg` holds:
  - The FSM state enum (`FEED_IDLE`, `FEED_STREAM`, `FEED_DRAIN`).
  - The default element width (`MAC_BW`).
  - The xsel width constant.
- Sub-module `skew_line`:
  - Parameters DEPTH and W; DEPTH registers.
  - Synchronous active-high clear.
  - Instantiated once per row with DEPTH = r+1.
- Top level holds the FSM, the counters and the handshake.

## Test plan
- ROWS=4, `cfg_len`=3, beats {1,2,3,4},{5,6,7,8},{9,10,11,12} with `in_valid` constant:
  - Row0 outputs 1,5,9 in cycles 1..3 after acceptance.
  - Row3 outputs 4,8,12 three cycles later.
  - `done` coincides with row3's 12.
- Same tile with `in_valid` low for 2 cycles after beat 1: every row shows a 2-cycle bubble (valid=0, data=0) between its first and second elements; `done` is delayed by 2.
- `start` with `cfg_len`=0: `done` pulses the next cycle, `o_valid` stays 0 and `busy` stays 0.
- `start` asserted during STREAM with a different `cfg_len`: ignored, and exactly the original `len` beats are accepted.
- `rst` asserted in DRAIN: all `o_valid`=0 the next cycle, no `done` pulse, FSM in IDLE, and a new tile then runs normally.
- With `UNO_FEEDER_XSEL_EN`: `in_xsel`=2'b10 on beat 2 appears on `o_xsel` row r in the same cycle as beat 2's data on row r.
